// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with memory-wait timeout.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_rd_wren_i,
  input  logic        ex_is_load_i,
  input  logic        ex_br_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic        pc_en_o,
  output logic        id_en_o,
  output logic        ex_en_o,
  output logic        mem_en_o,
  output logic        wb_en_o,
  output logic        id_flush_o,
  output logic        ex_flush_o,
  output logic        err_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT, ERROR} state_e;
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WMAX = WW'(WAIT_MAX);
  state_e state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic hz, stall;
  assign hz = ex_is_load_i & ex_rd_wren_i & (ex_rd_i != 5'd0) &
              ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) | (id_rs2_used_i & (id_rs2_i == ex_rd_i)));
  // In MEM_WAIT only readiness matters; a fresh mem_req is irrelevant there.
  assign stall = (state_q == RUN) ? (mem_req_i & ~mem_ready_i) : ~mem_ready_i;
  assign err_o = (state_q == ERROR);
  always_comb begin
    state_d = state_q;
    wait_d = wait_q;
    {pc_en_o, id_en_o, ex_en_o, mem_en_o, wb_en_o} = 5'b00000;
    {id_flush_o, ex_flush_o} = 2'b00;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (stall) begin
          state_d = (state_q == RUN) ? MEM_WAIT : (wait_q == WMAX) ? ERROR : MEM_WAIT;
          wait_d = (state_q == RUN) ? WW'(1) : (wait_q == WMAX) ? wait_q : wait_q + WW'(1);
        end else begin
          wait_d = '0;
          {pc_en_o, id_en_o, ex_en_o, mem_en_o, wb_en_o} = 5'b11111;
          state_d = ex_br_taken_i ? REDIRECT : RUN;
          id_flush_o = ex_br_taken_i;
          ex_flush_o = ex_br_taken_i | hz;
          pc_en_o = ex_br_taken_i | ~hz;
          id_en_o = ex_br_taken_i | ~hz;
        end
      end
      REDIRECT: begin
        {pc_en_o, id_en_o, ex_en_o, mem_en_o, wb_en_o} = 5'b11111;
        id_flush_o = 1'b1;
        state_d = RUN;
      end
      ERROR: state_d = ERROR;
    endcase
    if (!reset_ni) begin
      {pc_en_o, id_en_o, ex_en_o, mem_en_o, wb_en_o} = 5'b00000;
      {id_flush_o, ex_flush_o} = 2'b11;
    end
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= RUN;
      wait_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + ((!pc_en_o && state_q != ERROR && stall_cnt_q != '1) ? 32'd1 : 32'd0);
    flush_cnt_d = flush_cnt_q + (((id_flush_o || ex_flush_o) && flush_cnt_q != '1) ? 32'd1 : 32'd0);
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl (WAIT_MAX=4).
module tb_pipe_ctrl;
  logic clk_i = 1'b0, reset_ni = 1'b0;
  logic [4:0] id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
  logic id_rs1_used_i = 0, id_rs2_used_i = 0, ex_rd_wren_i = 0, ex_is_load_i = 0;
  logic ex_br_taken_i = 0, mem_req_i = 0, mem_ready_i = 0;
  logic pc_en_o, id_en_o, ex_en_o, mem_en_o, wb_en_o, id_flush_o, ex_flush_o, err_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;
  pipe_ctrl #(.WAIT_MAX(4)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_rd_i(ex_rd_i), .ex_rd_wren_i(ex_rd_wren_i), .ex_is_load_i(ex_is_load_i),
    .ex_br_taken_i(ex_br_taken_i), .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .pc_en_o(pc_en_o), .id_en_o(id_en_o), .ex_en_o(ex_en_o), .mem_en_o(mem_en_o),
    .wb_en_o(wb_en_o), .id_flush_o(id_flush_o), .ex_flush_o(ex_flush_o), .err_o(err_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  // {pc, id, ex, mem, wb, id_flush, ex_flush, err}
  localparam logic [7:0] NORM = 8'b11111_00_0, STALL = 8'b00000_00_0, BUB = 8'b00111_01_0,
                         BR = 8'b11111_11_0, RED = 8'b11111_10_0, ERR = 8'b00000_00_1,
                         RST = 8'b00000_11_0;
  typedef struct {logic [7:0] v; bit rst; string nm;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  logic [31:0] sc = 0, fc = 0;
  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e = q.pop_front();
      act = {pc_en_o, id_en_o, ex_en_o, mem_en_o, wb_en_o, id_flush_o, ex_flush_o, err_o};
      tests++;
      if (act !== e.v) begin
        fails++;
        $display("FAIL %s: outputs got %b expected %b", e.nm, act, e.v);
      end
      if (e.rst) begin
        sc = 0;
        fc = 0;
      end
      tests++;
      if (stall_cnt_o !== sc || flush_cnt_o !== fc) begin
        fails++;
        $display("FAIL %s_cnt: stall/flush got %0d/%0d expected %0d/%0d", e.nm, stall_cnt_o, flush_cnt_o, sc, fc);
      end
`ifdef PIPE_CTRL_PERF_EN
      if (!e.rst) begin
        if (!e.v[7] && !e.v[0]) sc = sc + 1;
        if (e.v[2] || e.v[1]) fc = fc + 1;
      end
`endif
    end
  end
  task automatic cyc(input logic [7:0] v, input string nm, input bit rst = 0);
    exp_t e;
    e.v = v;
    e.rst = rst;
    e.nm = nm;
    q.push_back(e);
    @(posedge clk_i);
    #1;
  endtask
  task automatic lu(input logic ld, input logic [4:0] rd, input logic wr,
                    input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
    ex_is_load_i = ld; ex_rd_i = rd; ex_rd_wren_i = wr;
    id_rs1_i = r1; id_rs1_used_i = u1; id_rs2_i = r2; id_rs2_used_i = u2;
  endtask
  initial begin
    @(posedge clk_i); #1;
    cyc(RST, "reset", 1);
    cyc(RST, "reset_hold", 1);
    reset_ni = 1;
    cyc(NORM, "run");
    lu(1, 5, 1, 0, 0, 5, 1); cyc(BUB, "lu_rs2");
    lu(0, 0, 0, 0, 0, 0, 0); cyc(NORM, "lu_after");
    lu(1, 7, 1, 7, 1, 0, 0); cyc(BUB, "lu_rs1");
    lu(1, 7, 1, 7, 0, 0, 0); cyc(NORM, "lu_unused");
    lu(1, 0, 1, 0, 0, 0, 1); cyc(NORM, "lu_x0");
    lu(0, 5, 1, 5, 1, 0, 0); cyc(NORM, "no_load");
    lu(1, 5, 0, 5, 1, 0, 0); cyc(NORM, "no_wren");
    lu(0, 0, 0, 0, 0, 0, 0);
    ex_br_taken_i = 1; cyc(BR, "br");
    ex_br_taken_i = 0; cyc(RED, "redirect");
    cyc(NORM, "br_after");
    ex_br_taken_i = 1; cyc(BR, "br2");
    mem_req_i = 1; mem_ready_i = 0; lu(1, 3, 1, 3, 1, 0, 0);
    cyc(RED, "redir_ignore");
    ex_br_taken_i = 0; mem_req_i = 0; lu(0, 0, 0, 0, 0, 0, 0);
    cyc(NORM, "redir_done");
    mem_req_i = 1; mem_ready_i = 0;
    cyc(STALL, "mem1"); cyc(STALL, "mem2"); cyc(STALL, "mem3");
    mem_ready_i = 1; cyc(NORM, "mem_ready");
    mem_req_i = 0; cyc(NORM, "mem_done");
    mem_req_i = 1; mem_ready_i = 0; ex_br_taken_i = 1;
    cyc(STALL, "membr1"); cyc(STALL, "membr2");
    mem_ready_i = 1; cyc(BR, "membr_ready");
    mem_req_i = 0; ex_br_taken_i = 0; cyc(RED, "membr_redir");
    cyc(NORM, "membr_done");
    mem_req_i = 1; mem_ready_i = 0; cyc(STALL, "memlu1");
    mem_ready_i = 1; lu(1, 9, 1, 0, 0, 9, 1); cyc(BUB, "memlu_ready");
    mem_req_i = 0; lu(0, 0, 0, 0, 0, 0, 0); cyc(NORM, "memlu_done");
    mem_req_i = 1; mem_ready_i = 0;
    for (int i = 0; i < 5; i++) cyc(STALL, $sformatf("to%0d", i));
    cyc(ERR, "err");
    mem_ready_i = 1; mem_req_i = 0; cyc(ERR, "err_sticky");
    reset_ni = 0; cyc(RST, "async_clr", 1);
    cyc(RST, "rst2", 1);
    reset_ni = 1; cyc(NORM, "post_rst");
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk_i);
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
